// File: rtl/int_source_pkg.sv
// Shared constants for the interrupt source: FSM state encoding and default acknowledge address.
package int_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam logic [31:0] ACK_ADDR_DEF = 32'h0000_7f20;
    localparam int          GAP_W        = 4;

endpackage

// File: rtl/int_source.sv
// Event-counting interrupt source acked by a full-word store to ACK_ADDR; trig at edge k raises interrupt from edge k.
// No backpressure: events beyond the counter's capacity are dropped and flagged in overflow.
module int_source
    import int_source_pkg::*;
#(
    parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF,
    parameter int          GAP      = 2,
    parameter int          CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic [31:0]      m_data_addr,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_data_wdata,
    output logic             interrupt,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [15:0]      ack_total,
    output logic             overflow,
    output logic             spurious
);

    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("int_source: GAP must be within 1..15");
    end

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    state_t             state, state_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [CNT_W-1:0]   pend_nxt;
    logic               ack, ack_ok, ovf_evt;

    // Write data carries no meaning here; kept on the port for bus probing only.
    logic unused_wdata;
    assign unused_wdata = ^m_data_wdata;

    assign ack    = (m_data_addr == ACK_ADDR) && (m_data_byteen == 4'b1111);
    assign ack_ok = ack && (state == ST_ASSERT);

    always_comb begin
        pend_nxt = pend_cnt;
        ovf_evt  = 1'b0;
        if (trig && !ack_ok) begin
            if (&pend_cnt) ovf_evt = 1'b1;
            else           pend_nxt = pend_cnt + CNT_W'(1);
        end else if (ack_ok && !trig && pend_cnt != '0) begin
            pend_nxt = pend_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (trig || pend_cnt != '0) state_nxt = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (ack) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                // Re-arm decision uses the count as it will be after this edge.
                if (gap_cnt == '0) state_nxt = (pend_nxt != '0) ? ST_ASSERT : ST_IDLE;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            interrupt <= 1'b0;
            pend_cnt  <= '0;
            ack_total <= '0;
            overflow  <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            interrupt <= (state_nxt == ST_ASSERT);
            pend_cnt  <= pend_nxt;
            if (ack_ok)             ack_total <= ack_total + 16'd1;
            if (ovf_evt)            overflow  <= 1'b1;
            if (ack && !(state == ST_ASSERT)) spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_int_source.sv
// Self-checking bench for int_source: directed table, corner-case sequences and randomized traffic vs. a reference model.
module tb_int_source;

    localparam logic [31:0] ACK    = 32'h0000_7f20;
    localparam int          GAPC   = 2;
    localparam int          MAXP   = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trig = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic        interrupt;
    logic [3:0]  pend_cnt;
    logic [15:0] ack_total;
    logic        overflow;
    logic        spurious;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: interrupt level, remaining forced-low cycles, pending events, counters.
    bit m_int;
    int m_gap, m_pend, m_tot;
    bit m_ovf, m_spur;

    int_source dut (
        .clk           (clk),
        .reset         (reset),
        .trig          (trig),
        .m_data_addr   (addr),
        .m_data_byteen (byteen),
        .m_data_wdata  (wdata),
        .interrupt     (interrupt),
        .pend_cnt      (pend_cnt),
        .ack_total     (ack_total),
        .overflow      (overflow),
        .spurious      (spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_int = 0; m_gap = 0; m_pend = 0; m_tot = 0; m_ovf = 0; m_spur = 0;
    endtask

    task automatic model_step(input bit t, input bit a);
        bit acc;
        int old_pend;
        acc      = a && m_int;
        old_pend = m_pend;
        if (t && !acc) begin
            if (m_pend == MAXP) m_ovf = 1;
            else                m_pend++;
        end else if (acc && !t) begin
            m_pend--;
        end
        if (a && !m_int) m_spur = 1;
        if (acc) m_tot = (m_tot + 1) % 65536;
        if (m_int) begin
            if (acc) begin
                m_int = 0;
                m_gap = GAPC;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_int = (m_pend > 0);
        end else begin
            m_int = t || (old_pend > 0);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".interrupt"}, interrupt, m_int);
        chk({tag, ".pend_cnt"},  pend_cnt,  m_pend);
        chk({tag, ".ack_total"}, ack_total, m_tot);
        chk({tag, ".overflow"},  overflow,  m_ovf);
        chk({tag, ".spurious"},  spurious,  m_spur);
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input string tag, input logic t, input logic [31:0] a, input logic [3:0] be);
        trig   = t;
        addr   = a;
        byteen = be;
        wdata  = $urandom;
        model_step(t, (a == ACK) && (be == 4'hF));
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        trig = 0; addr = '0; byteen = '0;
        @(negedge clk);
        reset = 0;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1;
    endtask

    typedef struct {
        logic       t;
        logic       at_ack;
        logic [3:0] be;
        logic       e_int;
        int         e_pend;
        int         e_tot;
        logic       e_spur;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Three back-to-back events acked as each asserts, then a partial and a stray full store.
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b0, 2, 1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 2, 1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 2, 1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1, 2, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1, 2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1, 2, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'hF, 1'b0, 0, 3, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 0, 3, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 0, 3, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 0, 3, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'h3, 1'b0, 0, 3, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'hF, 1'b0, 0, 3, 1'b1};

        model_reset();
        @(posedge clk);
        #1;
        compare_all("por");
        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle("tbl", tbl[i].t, tbl[i].at_ack ? ACK : 32'h0000_1000, tbl[i].be);
            chk($sformatf("tbl%0d.int", i),  interrupt, tbl[i].e_int);
            chk($sformatf("tbl%0d.pend", i), pend_cnt,  tbl[i].e_pend);
            chk($sformatf("tbl%0d.tot", i),  ack_total, tbl[i].e_tot);
            chk($sformatf("tbl%0d.spur", i), spurious,  tbl[i].e_spur);
        end

        // Single event at cycle 5, ack at cycle 10.
        do_reset();
        for (int c = 0; c < 5; c++) cycle("single_idle", 1'b0, '0, 4'h0);
        cycle("single_trig", 1'b1, '0, 4'h0);
        chk("single.int_on", interrupt, 1);
        chk("single.pend1", pend_cnt, 1);
        for (int c = 6; c < 10; c++) begin
            cycle("single_hold", 1'b0, '0, 4'h0);
            chk("single.held", interrupt, 1);
        end
        cycle("single_ack", 1'b0, ACK, 4'hF);
        chk("single.int_off", interrupt, 0);
        chk("single.pend0", pend_cnt, 0);
        chk("single.tot", ack_total, 1);
        for (int c = 0; c < 4; c++) begin
            cycle("single_after", 1'b0, '0, 4'h0);
            chk("single.low", interrupt, 0);
        end

        // Repeated ack on consecutive cycles counts once.
        do_reset();
        cycle("dbl_trig", 1'b1, '0, 4'h0);
        cycle("dbl_ack1", 1'b0, ACK, 4'hF);
        cycle("dbl_ack2", 1'b0, ACK, 4'hF);
        chk("dbl.tot", ack_total, 1);
        chk("dbl.spur", spurious, 1);

        // Saturation: 15 events fit, the 16th is lost.
        do_reset();
        for (int c = 0; c < 15; c++) cycle("sat", 1'b1, '0, 4'h0);
        chk("sat.no_ovf_yet", overflow, 0);
        cycle("sat16", 1'b1, '0, 4'h0);
        chk("sat.pend", pend_cnt, 15);
        chk("sat.ovf", overflow, 1);
        chk("sat.int", interrupt, 1);

        // Simultaneous trig and ack with two pending.
        do_reset();
        cycle("both_t1", 1'b1, '0, 4'h0);
        cycle("both_t2", 1'b1, '0, 4'h0);
        cycle("both", 1'b1, ACK, 4'hF);
        chk("both.pend", pend_cnt, 2);
        chk("both.int", interrupt, 0);
        cycle("both_g1", 1'b0, '0, 4'h0);
        chk("both.gap", interrupt, 0);
        cycle("both_g2", 1'b0, '0, 4'h0);
        chk("both.rearm", interrupt, 1);

        // Asynchronous reset while asserted with four pending.
        do_reset();
        for (int c = 0; c < 4; c++) cycle("rst_fill", 1'b1, '0, 4'h0);
        chk("rst.pend4", pend_cnt, 4);
        trig = 0;
        #3;
        reset = 0;
        model_reset();
        #1;
        chk("rst.int_now", interrupt, 0);
        chk("rst.pend_now", pend_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        for (int c = 0; c < 5; c++) begin
            cycle("rst_after", 1'b0, '0, 4'h0);
            chk("rst.quiet", interrupt, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic        t;
            logic [31:0] a;
            logic [3:0]  be;
            int          r;
            t = ($urandom_range(0, 99) < 35);
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                a = ACK; be = 4'hF;
            end else if (r == 3) begin
                a = ACK; be = 4'($urandom_range(0, 14));
            end else if (r == 4) begin
                a = ACK ^ 32'h4; be = 4'hF;
            end else begin
                a = $urandom & 32'hFFFF_0000; be = 4'($urandom);
            end
            cycle("rand", t, a, be);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_source.md
INT_SOURCE -- requirements
Module: int_source

Interface
REQ-001 The module SHALL have parameter ACK_ADDR, default 32'h0000_7f20, the word address whose full-word store acknowledges the interrupt.
REQ-002 The module SHALL have parameter GAP, default 2, legal range 1..15, the number of low cycles forced on interrupt after each acknowledge.
REQ-003 The module SHALL have parameter CNT_W, default 4, the width of the pending-event counter.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 trig  input  1  one event per cycle sampled high.
REQ-007 m_data_addr  input  32  data-bus address from the CPU top.
REQ-008 m_data_byteen  input  4  data-bus byte write enables.
REQ-009 m_data_wdata  input  32  data-bus write data; ignored apart from debug.
REQ-010 interrupt  output  1  registered request line into the CPU top.
REQ-011 pend_cnt  output  CNT_W  outstanding events, including the one currently asserted.
REQ-012 ack_total  output  16  count of accepted acknowledges, wrapping.
REQ-013 overflow  output  1  sticky; set when an event is lost.
REQ-014 spurious  output  1  sticky; set when an acknowledge arrives outside ASSERT.

Function
REQ-015 An acknowledge SHALL be defined as m_data_addr == ACK_ADDR and m_data_byteen == 4'b1111 in the same cycle.
REQ-016 The FSM SHALL have states IDLE, ASSERT and GAP, and interrupt SHALL equal 1 exactly in ASSERT.
REQ-017 IDLE SHALL go to ASSERT when trig == 1 or pend_cnt != 0; otherwise it stays in IDLE.
REQ-018 Latency: a trig sampled at edge k in IDLE SHALL produce interrupt = 1 from edge k until the acknowledge edge.
REQ-019 ASSERT SHALL hold until an acknowledge is sampled, then go to GAP and load the gap counter with GAP-1.
REQ-020 GAP SHALL decrement the gap counter each cycle; at 0 it goes to ASSERT if pend_cnt != 0 after this edge, otherwise to IDLE.
REQ-021 pend_cnt update: +1 on trig, -1 on acknowledge in ASSERT, unchanged when both occur in the same cycle.
REQ-022 pend_cnt SHALL saturate at 2^CNT_W-1; a trig while saturated without a same-cycle decrement sets overflow.
REQ-023 An acknowledge in IDLE or GAP SHALL be ignored for FSM and pend_cnt, and SHALL set spurious.
REQ-024 ack_total SHALL increment by 1 for each acknowledge accepted in ASSERT.
REQ-025 An acknowledge repeated on consecutive cycles SHALL count once; the second cycle falls in GAP and is spurious.

Reset
REQ-026 While reset == 0, the following SHALL hold asynchronously: state = IDLE, interrupt = 0, pend_cnt = 0, ack_total = 0, overflow = 0, spurious = 0, gap counter = 0.
REQ-027 Events in flight when reset is asserted mid-operation SHALL be discarded, and no interrupt SHALL be issued after reset is released without a new trig.
REQ-028 Reset deassertion SHALL be synchronized externally, and the first trig SHALL be sampled at the first rising edge with reset == 1.

Structure
REQ-029 The state encoding (IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2) and the default ACK_ADDR SHALL reside in the shared constant include file.
REQ-030 The design SHALL be a single module with no sub-modules; the acknowledge decode is an inline comparator.

Verification
REQ-031 Single trig at cycle 5, acknowledge at cycle 10 -> interrupt high for cycles 5..10; pend_cnt 1 then 0; ack_total = 1; low for 2 cycles, then IDLE.
REQ-032 Three trigs on consecutive cycles, then acknowledge each as soon as it asserts -> three assertions separated by exactly 2 low cycles; pend_cnt 3, 2, 1, 0.
REQ-033 Sixteen trigs with no acknowledge -> pend_cnt = 15, overflow = 1, interrupt held high.
REQ-034 Same-cycle trig and acknowledge with pend_cnt = 2 -> pend_cnt stays 2, GAP entered, reassert after 2 cycles.
REQ-035 Acknowledge with m_data_byteen = 4'b0011, then a full acknowledge in IDLE -> first ignored with no flag; second sets spurious = 1 and leaves ack_total unchanged.
REQ-036 Reset pulled low while in ASSERT with pend_cnt = 4 -> interrupt = 0 and pend_cnt = 0 immediately, and no assertion after release.
